// File: rtl/video_timing_gen_pkg.sv
// Shared definitions for the raster video timing generator.
//   - Test-pattern select encodings (PAT_*).
//   - Run-control FSM state type.
//   - Default 1280x720 timing constants.
package video_timing_gen_pkg;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } vtg_state_e;

  localparam int unsigned DEF_VIDEO_WIDTH      = 1280;
  localparam int unsigned DEF_VIDEO_HEIGHT     = 720;
  localparam int unsigned DEF_H_FRONT          = 110;
  localparam int unsigned DEF_H_SYNC           = 40;
  localparam int unsigned DEF_H_BACK           = 220;
  localparam int unsigned DEF_V_FRONT          = 5;
  localparam int unsigned DEF_V_SYNC           = 5;
  localparam int unsigned DEF_V_BACK           = 20;
  localparam int unsigned DEF_VIDEO_DATA_WIDTH = 8;

endpackage

// File: rtl/vtg_raster_counter.sv
// Horizontal/vertical raster counter.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   count_en   advance the raster by one pixel this cycle
//   h_cnt      pixel position within the line, 0..H_TOTAL-1
//   v_cnt      line position within the frame, 0..V_TOTAL-1
//   line_end   h_cnt is on the last pixel of the line
//   frame_end  v_cnt is on the last line of the frame (whole line);
//              the frame wraps when line_end && frame_end
module vtg_raster_counter #(
  parameter int unsigned H_TOTAL = 1650,
  parameter int unsigned V_TOTAL = 750,
  parameter int unsigned H_CNT_W = $clog2(H_TOTAL),
  parameter int unsigned V_CNT_W = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count_en,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               line_end,
  output logic               frame_end
);

  assign line_end  = (h_cnt == H_CNT_W'(H_TOTAL - 1));
  assign frame_end = (v_cnt == V_CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (count_en) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster video source with run control and selectable test patterns.
// Ports:
//   clk, rst         pixel clock, synchronous active-high reset
//   enable           run request; a started frame always completes
//   pattern_sel      test pattern (PAT_*), taken at each frame start
//   out_active       pixel valid
//   out_data         pixel value, 0 outside the active area
//   out_hsync        horizontal sync, active-high
//   out_vsync        vertical sync, active-high, whole lines
//   out_frame_start  one-cycle pulse on the first active pixel of a frame
//   busy             run-control FSM is not idle
//   out_frame_cnt    16-bit frame counter (only with VTG_FRAME_COUNTER_EN)
// Optional feature macro: VTG_FRAME_COUNTER_EN adds the frame counter and
// makes pattern 3 show its low bits instead of a constant mid-grey.
// All outputs are registered one cycle after the raster counters.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH      = DEF_VIDEO_WIDTH,
  parameter int unsigned VIDEO_HEIGHT     = DEF_VIDEO_HEIGHT,
  parameter int unsigned H_FRONT          = DEF_H_FRONT,
  parameter int unsigned H_SYNC           = DEF_H_SYNC,
  parameter int unsigned H_BACK           = DEF_H_BACK,
  parameter int unsigned V_FRONT          = DEF_V_FRONT,
  parameter int unsigned V_SYNC           = DEF_V_SYNC,
  parameter int unsigned V_BACK           = DEF_V_BACK,
  parameter int unsigned VIDEO_DATA_WIDTH = DEF_VIDEO_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  output logic                        out_active,
  output logic [VIDEO_DATA_WIDTH-1:0] out_data,
  output logic                        out_hsync,
  output logic                        out_vsync,
  output logic                        out_frame_start,
  output logic                        busy
`ifdef VTG_FRAME_COUNTER_EN
  ,
  output logic [15:0]                 out_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL     = VIDEO_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = VIDEO_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_CNT_W     = $clog2(H_TOTAL);
  localparam int unsigned V_CNT_W     = $clog2(V_TOTAL);
  localparam int unsigned HSYNC_START = VIDEO_WIDTH + H_FRONT;
  localparam int unsigned HSYNC_END   = VIDEO_WIDTH + H_FRONT + H_SYNC;
  localparam int unsigned VSYNC_START = VIDEO_HEIGHT + V_FRONT;
  localparam int unsigned VSYNC_END   = VIDEO_HEIGHT + V_FRONT + V_SYNC;

  vtg_state_e state_q, state_d;

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               line_end;
  logic               frame_end;
  logic               frame_wrap;
  logic               running;
  logic               frame_first;
  logic [31:0]        h_ext;
  logic [31:0]        v_ext;

  logic [1:0]                  pat_q;
  logic [1:0]                  pat_eff;
  logic                        pat_load;
  logic [VIDEO_DATA_WIDTH-1:0] pix;
  logic                        active_d;
  logic                        hsync_d;
  logic                        vsync_d;
  logic                        fs_d;
  logic [VIDEO_DATA_WIDTH-1:0] data_d;

  assign running     = (state_q != StIdle);
  assign frame_wrap  = line_end && frame_end;
  assign frame_first = (h_cnt == '0) && (v_cnt == '0);
  assign busy        = running;

  // Widened copies so decode compares and checkerboard bit 5 work for any
  // raster size.
  assign h_ext = 32'(h_cnt);
  assign v_ext = 32'(v_cnt);

  vtg_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_CNT_W (H_CNT_W),
    .V_CNT_W (V_CNT_W)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .count_en  (running),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Run control: RUN -> DRAIN on enable low; DRAIN only stops at a frame
  // wrap, so frames are never cut short.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if (frame_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pattern is sampled at the first pixel of each frame; that pixel itself
  // already uses the freshly selected pattern.
  assign pat_load = (state_q == StIdle) ? enable : frame_first;
  assign pat_eff  = frame_first ? pattern_sel : pat_q;

`ifdef VTG_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] fc_lat_q;
  logic [15:0] fc_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      fc_lat_q    <= '0;
    end else begin
      if (running && frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (pat_load) begin
        fc_lat_q <= frame_cnt_q;
      end
    end
  end

  assign fc_eff        = frame_first ? frame_cnt_q : fc_lat_q;
  assign out_frame_cnt = frame_cnt_q;
`endif

  always_comb begin
    pix = '0;
    case (pat_eff)
      PAT_HRAMP: pix = VIDEO_DATA_WIDTH'(h_cnt);
      PAT_VRAMP: pix = VIDEO_DATA_WIDTH'(v_cnt);
      PAT_CHECK: pix = {VIDEO_DATA_WIDTH{h_ext[5] ^ v_ext[5]}};
`ifdef VTG_FRAME_COUNTER_EN
      PAT_CONST: pix = VIDEO_DATA_WIDTH'(fc_eff);
`else
      PAT_CONST: pix = {1'b1, {(VIDEO_DATA_WIDTH - 1){1'b0}}};
`endif
      default:   pix = '0;
    endcase
  end

  always_comb begin
    active_d = running && (h_ext < VIDEO_WIDTH) && (v_ext < VIDEO_HEIGHT);
    hsync_d  = running && (h_ext >= HSYNC_START) && (h_ext < HSYNC_END);
    vsync_d  = running && (v_ext >= VSYNC_START) && (v_ext < VSYNC_END);
    fs_d     = active_d && frame_first;
    data_d   = active_d ? pix : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      pat_q           <= PAT_HRAMP;
      out_active      <= 1'b0;
      out_data        <= '0;
      out_hsync       <= 1'b0;
      out_vsync       <= 1'b0;
      out_frame_start <= 1'b0;
    end else begin
      state_q         <= state_d;
      if (pat_load) begin
        pat_q <= pattern_sel;
      end
      out_active      <= active_d;
      out_data        <= data_d;
      out_hsync       <= hsync_d;
      out_vsync       <= vsync_d;
      out_frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 4;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 2;
  localparam int unsigned HB = 2;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 1;
  localparam int unsigned VB = 1;
  localparam int unsigned DW = 8;
  localparam int HT = W + HF + HS + HB;  // 14
  localparam int VT = H + VF + VS + VB;  // 7
  localparam int FT = HT * VT;           // 98

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    pattern_sel;
  logic          out_active;
  logic [DW-1:0] out_data;
  logic          out_hsync;
  logic          out_vsync;
  logic          out_frame_start;
  logic          busy;
`ifdef VTG_FRAME_COUNTER_EN
  logic [15:0]   out_frame_cnt;
`endif

  video_timing_gen #(
    .VIDEO_WIDTH      (W),
    .VIDEO_HEIGHT     (H),
    .H_FRONT          (HF),
    .H_SYNC           (HS),
    .H_BACK           (HB),
    .V_FRONT          (VF),
    .V_SYNC           (VS),
    .V_BACK           (VB),
    .VIDEO_DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .pattern_sel     (pattern_sel),
    .out_active      (out_active),
    .out_data        (out_data),
    .out_hsync       (out_hsync),
    .out_vsync       (out_vsync),
    .out_frame_start (out_frame_start),
    .busy            (busy)
`ifdef VTG_FRAME_COUNTER_EN
    ,
    .out_frame_cnt   (out_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        active;
    logic [7:0]  data;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        busy;
    logic [15:0] fcnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a frame is a linear position 0..FT-1; a started frame
  // always finishes, and the source stops at a frame boundary only when
  // enable was low on the last two samples of that frame.
  bit         m_run = 0;
  int         m_pos = 0;
  bit         m_prev_en = 0;
  int         m_fc = 0;
  int         m_fc_lat = 0;
  logic [1:0] m_pat = 2'd0;

  function automatic logic [7:0] model_pix(int h, int v, logic [1:0] p, int fl);
    case (p)
      2'd0:    return 8'(h);
      2'd1:    return 8'(v);
      2'd2:    return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 8'hFF : 8'h00;
`ifdef VTG_FRAME_COUNTER_EN
      default: return 8'(fl);
`else
      default: return 8'h80;
`endif
    endcase
  endfunction

  always @(posedge clk) begin : model
    obs_t e;
    int   h;
    int   v;
    e = '0;
    if (rst) begin
      m_run = 0; m_pos = 0; m_prev_en = 0; m_fc = 0; m_fc_lat = 0; m_pat = 2'd0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_pos = 0; m_prev_en = 1;
      end
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      if (m_pos == 0) begin
        m_pat    = pattern_sel;
        m_fc_lat = m_fc;
      end
      e.active = (h < W) && (v < H);
      e.hs     = (h >= W + HF) && (h < W + HF + HS);
      e.vs     = (v >= H + VF) && (v < H + VF + VS);
      e.fs     = e.active && (m_pos == 0);
      e.data   = e.active ? model_pix(h, v, m_pat, m_fc_lat) : 8'h00;
      if (m_pos == FT - 1) begin
        m_fc = (m_fc + 1) & 16'hFFFF;
        if (!enable && !m_prev_en) m_run = 0;
      end
      m_pos     = (m_pos + 1) % FT;
      m_prev_en = enable;
    end
    e.busy = m_run;
`ifdef VTG_FRAME_COUNTER_EN
    e.fcnt = 16'(m_fc);
`endif
    exp_q.push_back(e);
  end

  int n_act = 0;
  int n_fs  = 0;
  int n_hs  = 0;
  int n_vs  = 0;

  always @(posedge clk) begin : monitor
    obs_t a;
    obs_t e;
    #1;
    a = '0;
    a.active = out_active;
    a.data   = out_data;
    a.hs     = out_hsync;
    a.vs     = out_vsync;
    a.fs     = out_frame_start;
    a.busy   = busy;
`ifdef VTG_FRAME_COUNTER_EN
    a.fcnt   = out_frame_cnt;
`endif
    if (out_active === 1'b1) n_act++;
    if (out_frame_start === 1'b1) n_fs++;
    if (out_hsync === 1'b1) n_hs++;
    if (out_vsync === 1'b1) n_vs++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard @%0t: no expected entry queued", $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display({"FAIL outputs @%0t: got act=%b data=%h hs=%b vs=%b fs=%b busy=%b fcnt=%0d,",
                  " required act=%b data=%h hs=%b vs=%b fs=%b busy=%b fcnt=%0d"},
                 $time, a.active, a.data, a.hs, a.vs, a.fs, a.busy, a.fcnt,
                 e.active, e.data, e.hs, e.vs, e.fs, e.busy, e.fcnt);
      end
    end
  end

  task automatic check_int(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Steps at least one cycle, then until the model's raster reaches target.
  task automatic wait_pos(int target);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_run && m_pos == target) && n < 3 * FT);
    if (!(m_run && m_pos == target)) begin
      checks++;
      errors++;
      $display("FAIL wait_pos %0d: got no match after %0d cycles, required a match", target, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_run && n < 3 * FT) begin
      @(negedge clk);
      n++;
    end
    if (m_run) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got still running after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_active", int'(out_active), 0);
    rst = 1'b0;
    @(negedge clk);

    // Two uninterrupted frames of pattern 0: independent per-frame tallies.
    n_act = 0; n_fs = 0; n_hs = 0; n_vs = 0;
    enable = 1'b1;
    repeat (2 * FT + 1) @(posedge clk);
    @(negedge clk);
    check_int("active_per_2_frames", n_act, 2 * W * H);
    check_int("frame_start_per_2_frames", n_fs, 2);
    check_int("hsync_per_2_frames", n_hs, 2 * HS * VT);
    check_int("vsync_per_2_frames", n_vs, 2 * VS * HT);

    // Vertical ramp, then a mid-frame switch that only lands next frame.
    pattern_sel = 2'd1;
    wait_pos(50);
    pattern_sel = 2'd3;
    wait_pos(0);
    wait_pos(40);

    // Drop enable at cycle 30: the frame runs out, then idle.
    wait_pos(30);
    enable = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 3 * FT);
    check_int("drain_cycles_to_idle", n, FT - 30);
    check_int("idle_active", int'(out_active), 0);
    repeat (10) @(negedge clk);

    // Drop and re-assert within one frame: no gap.
    enable = 1'b1;
    wait_pos(30);
    enable = 1'b0;
    wait_pos(90);
    enable = 1'b1;
    wait_pos(20);
    check_int("reenable_busy", int'(busy), 1);

    // Reset at line 2, pixel 3, then restart straight away.
    wait_pos(2 * HT + 3);
    rst = 1'b1;
    @(negedge clk);
    check_int("midframe_rst_busy", int'(busy), 0);
    check_int("midframe_rst_data", int'(out_data), 0);
    rst = 1'b0;
    repeat (2 * FT) @(negedge clk);

    // Randomised control traffic.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    enable = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
